// File: rtl/usb_pd_phy_tx_if.sv
// Message and handshake bundle between the protocol layer and the PD transmit PHY.
interface usb_pd_phy_tx_if;
  logic        start;
  logic        abort;
  logic        rd_role;
  logic [2:0]  msg_rev_dr;
  logic [2:0]  msg_id;
  logic [2:0]  msg_num;
  logic [4:0]  msg_type;
  logic        msg_pd3p1;
  logic [31:0] msg_word0;
  logic [31:0] msg_word1;
  logic [31:0] msg_word2;
  logic [31:0] msg_word3;
  logic [31:0] msg_word4;
  logic [31:0] msg_word5;
  logic [31:0] msg_word6;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, rd_role, msg_rev_dr, msg_id, msg_num, msg_type, msg_pd3p1,
    output msg_word0, msg_word1, msg_word2, msg_word3, msg_word4, msg_word5, msg_word6,
    input  busy, done
  );

  modport slave (
    input  start, abort, rd_role, msg_rev_dr, msg_id, msg_num, msg_type, msg_pd3p1,
    input  msg_word0, msg_word1, msg_word2, msg_word3, msg_word4, msg_word5, msg_word6,
    output busy, done
  );
endinterface

// File: rtl/usb_pd_phy_tx.sv
// USB PD transmit PHY: frames a latched message (preamble, SOP, 4b5b header/data/CRC32,
// EOP) and BMC-encodes it onto the CC line with a driver enable.
module usb_pd_phy_tx #(
  parameter int system_khz = 200000,
  parameter int bit_khz    = 300
) (
  input  logic           clock,
  input  logic           nrst,
  usb_pd_phy_tx_if.slave host,
  output logic           bmc_out,
  output logic           bmc_oe
);
  localparam int          HALF_UI   = system_khz / (2 * bit_khz);
  localparam logic [15:0] HALF_LAST = 16'(HALF_UI - 1);
  localparam logic [15:0] FULL_LAST = 16'(2 * HALF_UI - 1);
  localparam logic [4:0]  SYNC1     = 5'b11000;
  localparam logic [4:0]  SYNC2     = 5'b10001;
  localparam logic [4:0]  EOP_K     = 5'b01101;

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SOP, S_HDR, S_DATA, S_CRC, S_EOP, S_TAIL, S_DONE
  } state_t;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] sym;
    case (nib)
      4'h0: sym = 5'b11110;  4'h1: sym = 5'b01001;  4'h2: sym = 5'b10100;  4'h3: sym = 5'b10101;
      4'h4: sym = 5'b01010;  4'h5: sym = 5'b01011;  4'h6: sym = 5'b01110;  4'h7: sym = 5'b01111;
      4'h8: sym = 5'b10010;  4'h9: sym = 5'b10011;  4'hA: sym = 5'b10110;  4'hB: sym = 5'b10111;
      4'hC: sym = 5'b11010;  4'hD: sym = 5'b11011;  4'hE: sym = 5'b11100;  default: sym = 5'b11101;
    endcase
    return sym;
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [239:0] payload_q, payload_d;
  logic [2:0]   num_q, num_d;
  logic [31:0]  crc_q, crc_d;
  logic [4:0]   crc_cnt_q, crc_cnt_d;
  logic [15:0]  half_q, half_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [4:0]   sh_q, sh_d;
  logic [2:0]   rem_q, rem_d;
  logic         bmc_q, bmc_d;
  logic         oe_q, oe_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  crc_o;
  logic [5:0]   last_nib;
  logic [4:0]   crc_bytes;
  logic         cur_bit;
  logic         bit_end;
  logic [3:0]   nib_next;
  logic [3:0]   crc_nib_next;

  // Next-state logic: bit timing, symbol fetch, CRC accumulation, tail and abort handling.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    num_d     = num_q;
    crc_d     = crc_q;
    crc_cnt_d = crc_cnt_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rem_d     = rem_q;
    bmc_d     = bmc_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    crc_o        = ~crc_q;
    last_nib     = 6'd3 + {num_q, 3'b000};
    crc_bytes    = 5'd2 + {num_q, 2'b00};
    cur_bit      = (state_q == S_PREAMBLE) ? cnt_q[0] : sh_q[0];
    bit_end      = (half_q == FULL_LAST);
    nib_next     = payload_q[{cnt_q + 6'd1, 2'b00} +: 4];
    crc_nib_next = crc_o[{cnt_q[2:0] + 3'd1, 2'b00} +: 4];

    // The whole CRC is folded in during the preamble, well before its first symbol.
    if (state_q == S_PREAMBLE && crc_cnt_q != crc_bytes) begin
      crc_d     = crc_byte(crc_q, payload_q[{crc_cnt_q, 3'b000} +: 8]);
      crc_cnt_d = crc_cnt_q + 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          payload_d = {host.msg_word6, host.msg_word5, host.msg_word4, host.msg_word3,
                       host.msg_word2, host.msg_word1, host.msg_word0,
                       host.msg_pd3p1, host.msg_num, host.msg_id, host.rd_role,
                       host.msg_rev_dr, host.msg_type};
          num_d     = host.msg_num;
          crc_d     = 32'hFFFF_FFFF;
          crc_cnt_d = 5'd0;
          half_d    = 16'd0;
          cnt_d     = 6'd0;
          sh_d      = 5'd0;
          rem_d     = 3'd0;
          bmc_d     = 1'b1;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_PREAMBLE;
        end
      end

      S_TAIL: begin
        half_d = half_q + 16'd1;
        if (bmc_q) begin
          if (half_q == HALF_LAST) begin
            bmc_d  = 1'b0;
            half_d = 16'd0;
          end
        end else if (half_q == FULL_LAST) begin
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        half_d = half_q + 16'd1;
        if (half_q == HALF_LAST && cur_bit) begin
          bmc_d = ~bmc_q;
        end
        if (bit_end) begin
          half_d = 16'd0;
          bmc_d  = ~bmc_q;
          if (rem_q != 3'd0) begin
            sh_d  = sh_q >> 1;
            rem_d = rem_q - 3'd1;
          end else begin
            rem_d = 3'd4;
            case (state_q)
              S_PREAMBLE: begin
                rem_d = 3'd0;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                  state_d = S_SOP;
                  cnt_d   = 6'd0;
                  sh_d    = SYNC1;
                  rem_d   = 3'd4;
                end
              end
              S_SOP: begin
                if (cnt_q == 6'd3) begin
                  state_d = S_HDR;
                  cnt_d   = 6'd0;
                  sh_d    = enc_4b5b(payload_q[3:0]);
                end else begin
                  cnt_d = cnt_q + 6'd1;
                  sh_d  = (cnt_q == 6'd2) ? SYNC2 : SYNC1;
                end
              end
              S_HDR, S_DATA: begin
                if ((state_q == S_HDR && cnt_q == 6'd3 && num_q == 3'd0) ||
                    (state_q == S_DATA && cnt_q == last_nib)) begin
                  state_d = S_CRC;
                  cnt_d   = 6'd0;
                  sh_d    = enc_4b5b(crc_o[3:0]);
                end else begin
                  if (cnt_q == 6'd3) begin
                    state_d = S_DATA;
                  end
                  cnt_d = cnt_q + 6'd1;
                  sh_d  = enc_4b5b(nib_next);
                end
              end
              S_CRC: begin
                if (cnt_q == 6'd7) begin
                  state_d = S_EOP;
                  sh_d    = EOP_K;
                end else begin
                  cnt_d = cnt_q + 6'd1;
                  sh_d  = enc_4b5b(crc_nib_next);
                end
              end
              default: begin
                state_d = S_TAIL;
                bmc_d   = bmc_q;
                rem_d   = 3'd0;
              end
            endcase
          end
        end
      end
    endcase

    if (host.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      bmc_d   = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      payload_q <= '0;
      num_q     <= '0;
      crc_q     <= '0;
      crc_cnt_q <= '0;
      half_q    <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rem_q     <= '0;
      bmc_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      num_q     <= num_d;
      crc_q     <= crc_d;
      crc_cnt_q <= crc_cnt_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      bmc_q     <= bmc_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bmc_out   = bmc_q;
  assign bmc_oe    = oe_q;
  assign host.busy = busy_q;
  assign host.done = done_q;
endmodule

// File: doc/usb_pd_phy_tx.md
Name: usb_pd_phy_tx

Overview:
USB PD 3.1 physical-layer transmitter. It is the transmit-side counterpart of the receive PHY.
- Takes a parsed message: header fields plus up to 7 data words.
- Builds preamble, SOP, 4b5b-encoded header/data/CRC32 and EOP, then BMC-encodes onto the CC line with an output enable.
- Sits between the protocol layer and the CC pad driver.

Parameters:
- system_khz, 200000, system clock frequency in kHz.
- bit_khz, 300, BMC bit rate in kHz. HALF_UI = system_khz/(2*bit_khz), integer division (333 at defaults).

Ports:
- clock  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- abort  in  1  terminate the transmission in progress
- rd_role  in  1  header bit 8 (0 sink, 1 source)
- msg_rev_dr  in  3  header bits 7:5 (spec revision, data role)
- msg_id  in  3  header bits 11:9
- msg_num  in  3  header bits 14:12, number of data words (0..7)
- msg_type  in  5  header bits 4:0
- msg_pd3p1  in  1  header bit 15
- msg_word0..msg_word6  in  32 each  data objects; word0 is sent first
- bmc_out  out  1  BMC line level
- bmc_oe  out  1  CC driver enable
- busy  out  1  high from start accepted until DONE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, nrst=0): all outputs are 0; FSM goes to IDLE; half-UI counter, bit counter and CRC are cleared.
- Start acceptance: start=1 in IDLE latches all message inputs and resets CRC32. Next cycle: busy=1, bmc_oe=1, first preamble bit begins. start while busy is ignored.
- BMC encoding: bmc_out toggles at the start of every bit. A 1 bit also toggles after HALF_UI cycles; a 0 bit holds for 2*HALF_UI. The line level before the first bit is 0, so the first edge goes high.
- FSM states: IDLE -> PREAMBLE -> SOP -> HDR -> (DATA if msg_num!=0) -> CRC -> EOP -> TAIL -> DONE -> IDLE.
  - PREAMBLE: 64 bits alternating, starting with 0.
  - SOP: Sync1, Sync1, Sync1, Sync2.
  - HDR: 16-bit header as 4 symbols.
  - DATA: msg_num words of 8 symbols each.
  - CRC: 8 symbols.
  - EOP: 1 symbol.
- Symbols are 5 bits, sent LSB first.
  - K-codes: Sync1 = 5'b11000, Sync2 = 5'b10001, EOP = 5'b01101.
  - 4b5b table, nibble 0..F: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101.
- Byte and nibble order: little-endian bytes, low nibble first within each byte. The header is {msg_pd3p1, msg_num, msg_id, rd_role, msg_rev_dr, msg_type}.
- CRC32: the crc32 instance is fed one byte per enable: 2 header bytes, then 4 bytes per data word, in transmit order. Every CRC byte is applied before the first CRC symbol is sent. The value transmitted is crc_o, low nibble first.
- Symbol fetch timing: the next symbol is loaded on the last cycle of the current bit, so there is no gap between symbols.
- TAIL:
  - If bmc_out is high after the final EOP bit, hold high for HALF_UI more cycles, then drive 0.
  - Hold 0 for 2*HALF_UI cycles, then bmc_oe=0.
- DONE: one-cycle done=1, busy=0, return to IDLE.
- Total length: (64+20+20+40*msg_num+40+5) bits. msg_num=0 gives 149 bits; msg_num=7 gives 429 bits.
- abort=1 in any non-IDLE state:
  - next cycle bmc_out=0 and bmc_oe=0;
  - FSM goes to IDLE, busy=0, done is not pulsed.
- Simultaneous abort and start in IDLE: start wins, and abort is then honoured on the next cycle if still high.
- Input changes during busy have no effect, since the message is latched at start.

Test Plan:
- GoodCRC, msg_num=0, msg_type=5'h01, msg_id=3, rd_role=1 -> 149 bits. bmc_oe high for 149*666+tail cycles. The first 64 bits decode as 0101...; the SOP bits decode as 00011 00011 00011 10001 (as sent).
- msg_num=2, word0=32'h0001_912C, word1=32'h1234_5678 -> loop back into usb_pd_phy_rd -> pkg_valid=1, crc_valid=1, msg_num=2, msg_word0/1 match, rd_role/msg_id/msg_type match.
- msg_num=7, all words 32'hFFFF_FFFF -> loopback gives 7 matching words, crc_valid=1, done pulses exactly once.
- start pulsed again mid-DATA -> ignored; the frame is identical to a single-start run and only one done pulse occurs.
- abort asserted during CRC -> next cycle bmc_oe=0, bmc_out=0, busy=0, no done. The receiver returns to idle without pkg_valid.
- nrst low mid-preamble (async, off-edge) -> bmc_oe/bmc_out/busy go to 0 immediately. A new start after release produces a clean frame.
